// File: rtl/ram_2port_scan.sv
// Dual-port RAM with an independent write port and a self-scanning read port.
// Optional power-on clear sequence enabled by defining RAM_SCAN_CLEAR_EN.
module ram_2port_scan #(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned TICK_CYCLES = 50_000_000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              scan_en,
  input  logic              manual,
  input  logic              step,
  output logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data,
  output logic              tick,
  output logic              busy
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned PCNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_CYCLES - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              step_q;
  logic [DATA_W-1:0] rdata_q;
  logic              tick_c;
  logic              step_edge;
  logic              run;
  logic              clearing;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

`ifdef RAM_SCAN_CLEAR_EN
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Clear walks every address once, then hands over to RUN for good.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == {ADDR_W{1'b1}}) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign clearing = (state_q == ST_CLEAR);
  assign run      = ~clearing;
  assign busy     = clearing;
`else
  logic [ADDR_W-1:0] clr_addr_q;

  assign clr_addr_q = '0;
  assign clearing   = 1'b0;
  assign run        = 1'b1;
  assign busy       = 1'b0;
`endif

  // Prescaler and scan address; both hold while paused or clearing.
  always_comb begin
    pcnt_d    = pcnt_q;
    addr_d    = addr_q;
    tick_c    = 1'b0;
    step_edge = step & ~step_q;
    if (run && scan_en) begin
      if (manual) begin
        if (step_edge) begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end else if (pcnt_q == PCNT_LAST) begin
        tick_c = 1'b1;
        pcnt_d = '0;
        addr_d = addr_q + ADDR_W'(1);
      end else begin
        pcnt_d = pcnt_q + PCNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pcnt_q  <= '0;
      addr_q  <= '0;
      step_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      pcnt_q  <= pcnt_d;
      addr_q  <= addr_d;
      step_q  <= step;
      rdata_q <= run ? mem[addr_q] : '0;
    end
  end

  // Clear has priority on the write port; user writes drop while busy.
  assign mem_we    = clearing | (wr_en & run);
  assign mem_waddr = clearing ? clr_addr_q : wr_addr;
  assign mem_wdata = clearing ? '0 : wr_data;

  always_ff @(posedge CLOCK_50) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign read_addr = addr_q;
  assign read_data = rdata_q;
  assign tick      = tick_c;

endmodule

// File: tb/tb_ram_2port_scan.sv
// Self-checking bench for ram_2port_scan: table-driven scan vectors with a read-data
// scoreboard, plus hand sequences for wrap, TICK_CYCLES=1 and the clear option.
module tb_ram_2port_scan;

  typedef struct {
    logic       scan;
    logic       man;
    logic       stp;
    logic       we;
    logic [4:0] waddr;
    logic [3:0] wdata;
    logic       exp_tick;
    logic [4:0] exp_addr;
  } vec_t;

  logic       clk;
  logic       reset;

  logic       a_wr_en, a_scan_en, a_manual, a_step;
  logic [4:0] a_wr_addr, a_read_addr;
  logic [3:0] a_wr_data, a_read_data;
  logic       a_tick, a_busy;

  logic       b_wr_en, b_scan_en, b_manual, b_step;
  logic [1:0] b_wr_addr, b_read_addr;
  logic [3:0] b_wr_data, b_read_data;
  logic       b_tick, b_busy;

  int   n_checks;
  int   n_fail;
  vec_t vecs[$];
  logic [3:0] sb[$];
  logic [3:0] a_mem[32];
  logic [3:0] b_mem[4];

`ifdef RAM_SCAN_CLEAR_EN
  localparam logic EXP_BUSY_RST = 1'b1;
`else
  localparam logic EXP_BUSY_RST = 1'b0;
`endif

  ram_2port_scan #(.DATA_W(4), .ADDR_W(5), .TICK_CYCLES(4)) u_a (
    .CLOCK_50(clk), .reset(reset),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .scan_en(a_scan_en), .manual(a_manual), .step(a_step),
    .read_addr(a_read_addr), .read_data(a_read_data), .tick(a_tick), .busy(a_busy)
  );

  ram_2port_scan #(.DATA_W(4), .ADDR_W(2), .TICK_CYCLES(1)) u_b (
    .CLOCK_50(clk), .reset(reset),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .scan_en(b_scan_en), .manual(b_manual), .step(b_step),
    .read_addr(b_read_addr), .read_data(b_read_data), .tick(b_tick), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic s, input logic m, input logic st,
                                  input logic we, input logic [4:0] wa, input logic [3:0] wd,
                                  input logic et, input logic [4:0] ea);
    vec_t v;
    v.scan = s; v.man = m; v.stp = st; v.we = we;
    v.waddr = wa; v.wdata = wd; v.exp_tick = et; v.exp_addr = ea;
    vecs.push_back(v);
  endfunction

  task automatic wait_not_busy(input string name);
    int n;
    n = 0;
    #1;
    while (a_busy && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 32'(a_busy), 32'd0);
  endtask

  initial begin
    logic [3:0] exp_rd;
    int         n;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    a_wr_en = 0; a_wr_addr = '0; a_wr_data = '0; a_scan_en = 0; a_manual = 0; a_step = 0;
    b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0; b_scan_en = 0; b_manual = 0; b_step = 0;

    // Auto scan, pause, read-before-write, manual stepping, discarded step edge, mode return.
    for (int k = 0; k < 16; k++) add_vec(1, 0, 0, 0, 0, 0, (k % 4) == 3, 5'(k / 4));
    add_vec(1, 0, 0, 0, 0, 0, 0, 4);
    add_vec(1, 0, 0, 0, 0, 0, 0, 4);
    for (int k = 0; k < 5; k++) add_vec(0, 0, 0, 0, 0, 0, 0, 4);
    add_vec(1, 0, 0, 0, 0, 0, 0, 4);
    add_vec(1, 0, 0, 0, 0, 0, 1, 4);
    add_vec(1, 0, 0, 0, 0, 0, 0, 5);
    add_vec(0, 0, 0, 1, 5, 4'h5, 0, 5);
    add_vec(0, 0, 0, 0, 0, 0, 0, 5);
    add_vec(0, 0, 0, 0, 0, 0, 0, 5);
    add_vec(1, 1, 0, 0, 0, 0, 0, 5);
    add_vec(1, 1, 1, 0, 0, 0, 0, 5);
    for (int k = 0; k < 9; k++) add_vec(1, 1, 1, 0, 0, 0, 0, 6);
    add_vec(1, 1, 0, 0, 0, 0, 0, 6);
    add_vec(1, 1, 1, 0, 0, 0, 0, 6);
    add_vec(1, 1, 0, 0, 0, 0, 0, 7);
    add_vec(1, 1, 1, 0, 0, 0, 0, 7);
    add_vec(1, 1, 0, 0, 0, 0, 0, 8);
    add_vec(1, 1, 0, 0, 0, 0, 0, 8);
    add_vec(0, 1, 1, 0, 0, 0, 0, 8);
    add_vec(1, 1, 1, 0, 0, 0, 0, 8);
    add_vec(1, 1, 0, 0, 0, 0, 0, 8);
    add_vec(1, 1, 1, 0, 0, 0, 0, 8);
    add_vec(1, 0, 0, 0, 0, 0, 0, 9);
    add_vec(1, 0, 0, 0, 0, 0, 0, 9);
    add_vec(1, 0, 0, 1, 9, 4'hC, 1, 9);
    add_vec(1, 0, 0, 0, 0, 0, 0, 10);
    add_vec(1, 0, 0, 0, 0, 0, 0, 10);

`ifdef RAM_SCAN_CLEAR_EN
    // Power-on clear: length, dropped writes, all-zero contents, restart on reset.
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    a_wr_en = 1'b1; a_wr_data = 4'hF;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      a_wr_addr = 5'(c);
      #1;
      if (!a_busy) break;
      n++;
      @(negedge clk);
    end
    a_wr_en = 1'b0;
    check("clear_len", 32'(n), 32'd32);
    a_scan_en = 1'b1; a_manual = 1'b1;
    for (int a = 0; a < 32; a++) begin
      @(negedge clk); a_step = 1'b0;
      @(negedge clk); a_step = 1'b0; #1;
      check($sformatf("clear_addr%0d", a), 32'(a_read_addr), 32'(a));
      check($sformatf("clear_data%0d", a), 32'(a_read_data), 32'd0);
      @(negedge clk); a_step = 1'b1;
    end
    @(negedge clk); a_step = 1'b0; a_scan_en = 1'b0; a_manual = 1'b0;
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 10; c++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (!a_busy) break;
      n++;
      @(negedge clk);
    end
    check("clear_restart_len", 32'(n), 32'd32);
    reset = 1'b1;
`endif

    // Reset values, sampled while reset is still asserted.
    @(negedge clk); @(negedge clk); #1;
    check("rst_addr", 32'(a_read_addr), 32'd0);
    check("rst_data", 32'(a_read_data), 32'd0);
    check("rst_tick", 32'(a_tick), 32'd0);
    check("rst_busy", 32'(a_busy), 32'(EXP_BUSY_RST));
    check("rst_b_addr", 32'(b_read_addr), 32'd0);
    check("rst_b_tick", 32'(b_tick), 32'd0);
    @(negedge clk); reset = 1'b0;
    if (EXP_BUSY_RST) wait_not_busy("busy_timeout");

    // Load every address of the main instance with a known pattern.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      a_wr_en = 1'b1; a_wr_addr = 5'(i); a_wr_data = 4'((i * 7 + 3) & 15);
      a_mem[i] = 4'((i * 7 + 3) & 15);
    end
    @(negedge clk);
    a_wr_addr = 5'd3; a_wr_data = 4'hA; a_mem[3] = 4'hA;
    @(negedge clk);
    a_wr_en = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      a_scan_en = vecs[i].scan; a_manual = vecs[i].man; a_step = vecs[i].stp;
      a_wr_en = vecs[i].we; a_wr_addr = vecs[i].waddr; a_wr_data = vecs[i].wdata;
      #1;
      if (sb.size() > 0) begin
        exp_rd = sb.pop_front();
        check($sformatf("vec%0d_data", i), 32'(a_read_data), 32'(exp_rd));
      end
      check($sformatf("vec%0d_tick", i), 32'(a_tick), 32'(vecs[i].exp_tick));
      check($sformatf("vec%0d_addr", i), 32'(a_read_addr), 32'(vecs[i].exp_addr));
      sb.push_back(a_mem[vecs[i].exp_addr]);
      if (vecs[i].we) a_mem[vecs[i].waddr] = vecs[i].wdata;
    end
    @(negedge clk);
    a_scan_en = 1'b0; a_manual = 1'b0; a_step = 1'b0; a_wr_en = 1'b0;
    #1;
    exp_rd = sb.pop_front();
    check("vec_last_data", 32'(a_read_data), 32'(exp_rd));
    sb.delete();

    // Four-entry instance with a one-cycle tick: continuous advance and wrap.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_wr_en = 1'b1; b_wr_addr = 2'(i); b_wr_data = 4'(i + 1);
      b_mem[i] = 4'(i + 1);
    end
    @(negedge clk);
    b_wr_en = 1'b0;
    #1;
    check("b_paused_tick", 32'(b_tick), 32'd0);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      b_scan_en = 1'b1;
      #1;
      check($sformatf("b_tick%0d", j), 32'(b_tick), 32'd1);
      check($sformatf("b_addr%0d", j), 32'(b_read_addr), 32'(j % 4));
      if (j > 0) check($sformatf("b_data%0d", j), 32'(b_read_data), 32'(b_mem[(j - 1) % 4]));
    end
    @(negedge clk);
    b_scan_en = 1'b0;
    #1;
    check("b_stop_tick", 32'(b_tick), 32'd0);
    check("b_stop_addr", 32'(b_read_addr), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
